// File: rtl/i2c_slave_ctrl_if.sv
// i2c_slave_ctrl_if: I2C pad and register-memory signals of the slave engine
interface i2c_slave_ctrl_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en;
  logic [7:0] mem_rdata;
  logic       busy;
  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_wr_en, busy
  );
  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_wr_en, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C slave engine driving a 128x8 register memory; define I2C_GLITCH_FILTER_EN for 3-sample SCL/SDA filtering
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  i2c_slave_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl, sda, scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] sh_q, sh_d, wdata_q, wdata_d, byte_in;
  logic [6:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic sda_oe_q, sda_oe_d, wr_en_q, wr_en_d, busy_q, busy_d, pend_q, pend_d;

  // pad synchronisers plus one history sample of the lines used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_p_q <= scl;
      sda_p_q <= sda;
    end
  end
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  // two older samples; a line only changes once three consecutive samples agree
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s};
      sda_h_q <= {sda_h_q[0], sda_s};
    end
  end
  assign scl = (scl_s & (&scl_h_q)) | (scl_p_q & (scl_s | (|scl_h_q)));
  assign sda = (sda_s & (&sda_h_q)) | (sda_p_q & (sda_s | (|sda_h_q)));
`else
  assign scl = scl_s;
  assign sda = sda_s;
`endif
  assign scl_rise = scl & ~scl_p_q;
  assign scl_fall = ~scl & scl_p_q;
  assign start = scl & scl_p_q & sda_p_q & ~sda;
  assign stop = scl & scl_p_q & ~sda_p_q & sda;
  assign byte_in = {sh_q[6:0], sda};

  // protocol state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      sda_oe_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b1;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      sda_oe_q <= sda_oe_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // next state; the write pulse runs independently so a START during it still completes the write
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    sda_oe_d = sda_oe_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b1;
    busy_d = busy_q;
    pend_d = 1'b0;
    if (pend_q) begin
      wdata_d = sh_q;
      wr_en_d = 1'b0;
    end
    if (!wr_en_q) addr_d = addr_q + 7'd1;
    if (stop) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      state_d = ADDR;
      sda_oe_d = 1'b0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: busy_d = 1'b0;
        ADDR, PTR, WDATA: if (scl_rise) begin
          sh_d = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
              busy_d = busy_q | (byte_in[7:1] == SLAVE_ADDR);
            end else if (state_q == PTR) begin
              addr_d = byte_in[6:0];
              state_d = PTR_ACK;
            end else begin
              pend_d = 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q) begin
            state_d = (state_q == ADDR_ACK) ? (sh_q[0] ? RDATA : PTR) : WDATA;
            if (state_q == ADDR_ACK && sh_q[0]) begin
              sh_d = bus.mem_rdata;
              sda_oe_d = ~bus.mem_rdata[7];
            end
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            sh_d = {sh_q[6:0], 1'b0};
            sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~sh_q[6];
            cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q;
            state_d = (cnt_q == 4'd8) ? RDATA_ACK : RDATA;
          end
        end
        RDATA_ACK: if (scl_rise) begin
          addr_d = addr_q + 7'd1;
          cnt_d = 4'd1;
          state_d = sda ? WAIT_STOP : RDATA_ACK;
        end else if (scl_fall && cnt_q == 4'd1) begin
          cnt_d = '0;
          sh_d = bus.mem_rdata;
          sda_oe_d = ~bus.mem_rdata[7];
          state_d = RDATA;
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed vectors and a transaction-level model against the I2C slave engine
module tb_i2c_slave_ctrl;
  localparam int Q = 8;
  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    int n;
    logic [23:0] d;
    logic ack;
    logic [6:0] wr_addr;
    logic [6:0] end_addr;
  } vec_t;

  logic clk, reset, scl_m, sda_m, sda_line;
  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  logic [6:0] ref_ptr;
  logic [6:0] wr_log_a [1024];
  logic [7:0] wr_log_d [1024];
  int wr_n, busy_cnt, oe_cnt, wr_long;
  int n_chk, n_fail;
  logic prev_low;

  i2c_slave_ctrl_if bus ();
  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  assign sda_line = sda_m & ~bus.sda_oe;
  assign bus.sda_in = sda_line;
  assign bus.scl_in = scl_m;
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_n = 0; busy_cnt = 0; oe_cnt = 0; wr_long = 0; prev_low = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 5);
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_wr_en === 1'b0) begin
          wr_log_a[wr_n] = bus.mem_addr;
          wr_log_d[wr_n] = bus.mem_wdata;
          mem[bus.mem_addr] = bus.mem_wdata;
          if (prev_low) wr_long++;
          wr_n++;
        end
        prev_low = (bus.mem_wr_en === 1'b0);
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.sda_oe === 1'b1) oe_cnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack_line);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      b[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  initial begin
    vec_t vecs [6];
    logic a;
    logic [7:0] db, rb;
    logic [7:0] rd [3];
    logic [6:0] p, dev7;
    int base, b0, o0, nw, kind, n;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 37 + 5);
    tick(4);
    reset = 1'b0;
    tick(2);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 1);
    chk("rst_busy", bus.busy, 0);

    vecs[0] = '{8'hA0, 8'h10, 1, 24'h0000A5, 1'b1, 7'h10, 7'h11};
    vecs[1] = '{8'hA2, 8'h10, 1, 24'h0000A5, 1'b0, 7'h00, 7'h11};
    vecs[2] = '{8'hA0, 8'h7F, 2, 24'h002211, 1'b1, 7'h7F, 7'h01};
    vecs[3] = '{8'hA0, 8'h8F, 1, 24'h00005A, 1'b1, 7'h0F, 7'h10};
    vecs[4] = '{8'hA0, 8'h40, 3, 24'hC0FFEE, 1'b1, 7'h40, 7'h43};
    vecs[5] = '{8'h51, 8'h00, 1, 24'h000077, 1'b0, 7'h00, 7'h43};
    for (int v = 0; v < 6; v++) begin
      base = wr_n; b0 = busy_cnt; o0 = oe_cnt;
      i2c_start();
      send_byte(vecs[v].dev, a);
      chk("vec_dev_ack", a, !vecs[v].ack);
      send_byte(vecs[v].ptr, a);
      chk("vec_ptr_ack", a, !vecs[v].ack);
      for (int i = 0; i < vecs[v].n; i++) begin
        db = vecs[v].d[8*i +: 8];
        send_byte(db, a);
        chk("vec_data_ack", a, !vecs[v].ack);
      end
      i2c_stop();
      tick(Q);
      nw = vecs[v].ack ? vecs[v].n : 0;
      chk("vec_wr_count", wr_n - base, nw);
      for (int i = 0; i < nw && base + i < wr_n; i++) begin
        chk("vec_wr_addr", wr_log_a[base+i], 7'(vecs[v].wr_addr + 7'(i)));
        chk("vec_wr_data", wr_log_d[base+i], vecs[v].d[8*i +: 8]);
      end
      for (int i = 0; i < nw; i++) ref_mem[7'(vecs[v].wr_addr + 7'(i))] = vecs[v].d[8*i +: 8];
      chk("vec_end_addr", bus.mem_addr, vecs[v].end_addr);
      chk("vec_busy_seen", busy_cnt != b0, vecs[v].ack);
      chk("vec_oe_seen", oe_cnt != o0, vecs[v].ack);
      chk("vec_busy_idle", bus.busy, 0);
    end
    ref_ptr = 7'h43;

    i2c_start();
    send_byte(8'hA0, a); send_byte(8'h20, a); send_byte(8'h3C, a); send_byte(8'hC3, a);
    i2c_stop();
    ref_mem[7'h20] = 8'h3C; ref_mem[7'h21] = 8'hC3;
    i2c_start();
    send_byte(8'hA0, a); chk("rd_dev_ack", a, 0);
    send_byte(8'h20, a); chk("rd_ptr_ack", a, 0);
    i2c_start();
    send_byte(8'hA1, a); chk("rd_sr_ack", a, 0);
    read_byte(rb, 1'b0); chk("rd_byte0", rb, 8'h3C);
    read_byte(rb, 1'b1); chk("rd_byte1", rb, 8'hC3);
    chk("rd_oe_after_nack", bus.sda_oe, 0);
    i2c_stop();
    tick(Q);
    chk("rd_end_addr", bus.mem_addr, 7'h22);
    chk("rd_busy_idle", bus.busy, 0);

    base = wr_n;
    i2c_start();
    send_byte(8'hA0, a); send_byte(8'h30, a);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, a);
    i2c_stop();
    tick(Q);
    chk("abort_no_write", wr_n - base, 0);
    chk("abort_addr", bus.mem_addr, 7'h30);
    chk("abort_busy", bus.busy, 0);
    ref_ptr = 7'h30;

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      p = 7'($urandom);
      n = $urandom_range(1, 3);
      base = wr_n;
      i2c_start();
      if (kind == 0) begin
        send_byte(8'hA0, a); chk("rnd_w_dev_ack", a, 0);
        send_byte({1'($urandom), p}, a); chk("rnd_w_ptr_ack", a, 0);
        for (int i = 0; i < n; i++) begin
          rd[i] = 8'($urandom);
          send_byte(rd[i], a); chk("rnd_w_data_ack", a, 0);
        end
        i2c_stop();
        tick(Q);
        chk("rnd_w_count", wr_n - base, n);
        for (int i = 0; i < n && base + i < wr_n; i++) begin
          chk("rnd_w_addr", wr_log_a[base+i], 7'(p + 7'(i)));
          chk("rnd_w_data", wr_log_d[base+i], rd[i]);
        end
        for (int i = 0; i < n; i++) ref_mem[7'(p + 7'(i))] = rd[i];
        ref_ptr = 7'(p + 7'(n));
      end else if (kind == 1) begin
        dev7 = 7'($urandom);
        if (dev7 == 7'h50) dev7 = 7'h51;
        send_byte({dev7, 1'b0}, a); chk("rnd_x_dev_nack", a, 1);
        send_byte({1'b0, p}, a); chk("rnd_x_ptr_nack", a, 1);
        send_byte(8'($urandom), a); chk("rnd_x_data_nack", a, 1);
        i2c_stop();
        tick(Q);
        chk("rnd_x_count", wr_n - base, 0);
      end else begin
        send_byte(8'hA0, a); chk("rnd_r_dev_ack", a, 0);
        send_byte({1'b0, p}, a); chk("rnd_r_ptr_ack", a, 0);
        i2c_start();
        send_byte(8'hA1, a); chk("rnd_r_sr_ack", a, 0);
        for (int i = 0; i < n; i++) begin
          read_byte(rb, i == n - 1);
          chk("rnd_r_data", rb, ref_mem[7'(p + 7'(i))]);
        end
        i2c_stop();
        tick(Q);
        ref_ptr = 7'(p + 7'(n));
      end
      chk("rnd_end_addr", bus.mem_addr, ref_ptr);
      chk("rnd_busy_idle", bus.busy, 0);
    end

`ifdef I2C_GLITCH_FILTER_EN
    b0 = busy_cnt;
    tick(Q);
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(Q);
    send_byte(8'hA0, a);
    chk("glitch_no_ack", a, 1);
    i2c_stop();
    tick(Q);
    chk("glitch_no_busy", busy_cnt != b0, 0);
`endif

    i2c_start();
    send_byte(8'hA0, a); send_byte(8'h20, a);
    i2c_start();
    send_byte(8'hA1, a);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, a);
    reset = 1'b1;
    tick(1);
    chk("mrst_sda_oe", bus.sda_oe, 0);
    chk("mrst_wr_en", bus.mem_wr_en, 1);
    chk("mrst_addr", bus.mem_addr, 0);
    chk("mrst_busy", bus.busy, 0);
    reset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    tick(2 * Q);

    chk("wr_pulse_len", wr_long, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- I2C slave protocol engine that sits directly upstream of the 128x8 register memory.
- Oversamples SCL/SDA on the system clock and decodes START, STOP, device address, R/W, register pointer and data bytes.
- Drives the memory's address, write-data and active-low write-enable, and serialises memory read data back onto SDA.
- Single register pointer with auto-increment for burst reads and writes.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address this slave answers to.
SYNC_STAGES, 2, flop stages in the SCL/SDA input synchronisers (minimum 2).

Ports:
clk  input  1  system clock; frequency at least 10x SCL.
reset  input  1  synchronous, active-high reset.
scl_in  input  1  I2C clock from pad (asynchronous).
sda_in  input  1  I2C data from pad (asynchronous).
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
mem_addr  output  7  register pointer to memory address port.
mem_wdata  output  8  write data to memory.
mem_wr_en  output  1  memory write enable, active low: 0 = write for one clk, 1 = read.
mem_rdata  input  8  combinational read data from memory at mem_addr.
busy  output  1  1 from a START that matches SLAVE_ADDR until STOP or return to IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, sda_oe=0, mem_addr=0, mem_wdata=0, mem_wr_en=1, busy=0, shift register and bit counter = 0.
- Synchroniser: SYNC_STAGES flops on scl_in and sda_in, plus one history flop each. All detection uses the synchronised signals.
  - scl_rise / scl_fall are single-clk pulses.
  - START = synchronised SDA 1->0 while SCL high. STOP = SDA 0->1 while SCL high.
- Bit timing: SDA is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall.
- STOP in any state -> IDLE: sda_oe=0, busy=0, no memory write for a partial byte.
- START in any state, including a repeated START -> ADDR with bit counter cleared. The pointer is retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Address match -> ADDR_ACK.
    - Mismatch -> WAIT_STOP, with sda_oe=0 throughout.
  - ADDR_ACK: on the scl_fall after the 8th bit, sda_oe=1 for one SCL period; released on the next scl_fall.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA; shift register loaded from mem_rdata on the releasing scl_fall.
  - PTR: shift 8 bits; mem_addr <= byte[6:0] (bit7 ignored) -> PTR_ACK (ACK as above) -> WDATA.
  - WDATA: shift 8 bits.
    - On the clk after the 8th scl_rise: mem_wdata <= byte, mem_wr_en=0 for exactly one clk.
    - Next clk: mem_wr_en=1, mem_addr <= mem_addr+1.
    - -> WDATA_ACK (ACK) -> WDATA.
  - RDATA: drive shift-register MSB each scl_fall (sda_oe = ~bit). After 8 bits, release SDA -> RDATA_ACK.
  - RDATA_ACK: sample master bit on scl_rise; mem_addr <= mem_addr+1.
    - ACK (0): reload shift register from mem_rdata at the new address on the next scl_fall -> RDATA.
    - NACK (1) -> WAIT_STOP.
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- Pointer arithmetic is 7-bit modulo: 7'h7F + 1 = 7'h00.
- mem_wr_en is 1 in every cycle except the single write pulse.
- busy=1 from the ADDR match through to IDLE.
- A START arriving in the same clk as the write pulse: the write completes, then ADDR.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after synchronisation, each of SCL and SDA passes a 3-sample consistency filter. The filtered output changes only when 3 consecutive samples agree. Pulses shorter than 3 clk are rejected. Input-to-detect latency grows by 2 clk.
- Undefined: the synchronised signals are used directly.

Test Plan:
- Write: START, 0xA0, ptr 0x10, data 0xA5, STOP -> three ACKs (sda_oe=1 in each 9th bit); one clk with mem_wr_en=0, mem_addr=0x10, mem_wdata=0xA5; mem_addr=0x11 after.
- Address mismatch: START, 0xA2, 0x10 -> sda_oe never asserted; busy=0; no mem_wr_en pulse; IDLE after STOP.
- Read with repeated START: preload mem[0x20]=0x3C and mem[0x21]=0xC3. START, 0xA0, ptr 0x20, Sr, 0xA1, read 2 bytes (master ACK then NACK), STOP -> SDA carries 0x3C then 0xC3; mem_addr ends at 0x22; sda_oe=0 after the NACK.
- Burst wrap: ptr 0x7F, data 0x11, 0x22 -> write pulses at 0x7F then 0x00.
- Abort: STOP after 4 data bits -> no write pulse; state IDLE; mem_addr unchanged.
- Mid-transfer reset: assert reset during RDATA -> next clk sda_oe=0, mem_wr_en=1, mem_addr=0, busy=0. With I2C_GLITCH_FILTER_EN, a 1-clk SDA low pulse while SCL is high does not cause START.
